// File: rtl/vscale_fetch_stage_pkg.sv
// Shared constants and types for the vscale instruction-fetch stage.
package vscale_fetch_stage_pkg;

  localparam int FETCH_STATE_W = 1;
  localparam logic [FETCH_STATE_W-1:0] FETCH_BOOT = 1'b0;
  localparam logic [FETCH_STATE_W-1:0] FETCH_RUN  = 1'b1;

  localparam int FETCH_Q_DEPTH = 2;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/vscale_fetch_fifo.sv
// Two-entry {pc, inst} FIFO with push/pop/flush; used for fetched words and pending request PCs.
module vscale_fetch_fifo
  import vscale_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_inst,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_inst,
  output logic [1:0]  count
);

  fetch_entry_t entries [FETCH_Q_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & (count != 2'(FETCH_Q_DEPTH));
  assign do_pop  = pop & (count != 2'd0);
  assign rd_pc   = entries[rd_ptr].pc;
  assign rd_inst = entries[rd_ptr].inst;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // NOTE: entry storage is not reset; count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) entries[wr_ptr] <= '{pc: wr_pc, inst: wr_inst};
  end

endmodule

// File: rtl/vscale_fetch_stage.sv
// Instruction fetch: issues sequential imem requests with two credits, buffers words, presents them to DX.
module vscale_fetch_stage
  import vscale_fetch_stage_pkg::*;
#(
  parameter logic [31:0] START_PC = 32'h0000_0200,
  parameter logic [31:0] NOP_INST = RV_NOP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] PC_PIF,
  input  logic        redirect,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid_IF,
  input  logic        dx_ready,
  output logic [31:0] PC_IF,
  output logic [31:0] inst_IF
);

  logic [FETCH_STATE_W-1:0] state;
  logic [31:0] fetch_pc;
  logic [31:0] last_pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop_cnt;
  logic [1:0]  inst_count;
  logic [31:0] head_pc;
  logic [31:0] head_inst;
  logic [31:0] pend_pc;
  logic [31:0] unused_pend_inst;
  logic [1:0]  unused_pend_count;
  logic [2:0]  occupancy;
  logic        pop;
  logic        credit;
  logic        accept;
  logic        push_inst;

  assign inst_valid_IF  = (inst_count != 2'd0) & ~redirect;
  assign pop            = inst_valid_IF & dx_ready;
  // A slot freed by this cycle's pop may be re-used by this cycle's request.
  assign occupancy      = {1'b0, outstanding} + {1'b0, inst_count};
  assign credit         = occupancy < (3'd2 + {2'b00, pop});
  assign imem_req_valid = (state == FETCH_RUN) & credit & ~redirect;
  assign imem_addr      = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign push_inst      = imem_resp_valid & ~redirect & (drop_cnt == 2'd0);
  assign PC_IF          = (inst_count != 2'd0) ? head_pc : last_pc;
  assign inst_IF        = (inst_count != 2'd0) ? head_inst : NOP_INST;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH_BOOT;
      fetch_pc    <= START_PC;
      last_pc     <= START_PC - 32'd4;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      if (state == FETCH_BOOT) state <= FETCH_RUN;

      if (redirect)    fetch_pc <= PC_PIF;
      else if (accept) fetch_pc <= fetch_pc + 32'd4;

      if (pop) last_pc <= head_pc;

      case ({accept, imem_resp_valid})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase

      // Every request still in flight at a redirect is stale, including one answering now.
      if (redirect)                                   drop_cnt <= outstanding - {1'b0, imem_resp_valid};
      else if (imem_resp_valid && drop_cnt != 2'd0)   drop_cnt <= drop_cnt - 2'd1;
    end
  end

  vscale_fetch_fifo u_inst_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_inst),
    .pop     (pop),
    .flush   (redirect),
    .wr_pc   (pend_pc),
    .wr_inst (imem_resp_data),
    .rd_pc   (head_pc),
    .rd_inst (head_inst),
    .count   (inst_count)
  );

  vscale_fetch_fifo u_pend_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (imem_resp_valid),
    .flush   (1'b0),
    .wr_pc   (fetch_pc),
    .wr_inst (32'd0),
    .rd_pc   (pend_pc),
    .rd_inst (unused_pend_inst),
    .count   (unused_pend_count)
  );

endmodule

// File: tb/tb_vscale_fetch_stage.sv
// Bench for vscale_fetch_stage: queue-level fetch model plus an in-order imem model with variable latency.
module tb_vscale_fetch_stage;

  localparam logic [31:0] START = 32'h0000_0200;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] PC_PIF = '0;
  logic        redirect = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid_IF;
  logic        dx_ready = 1'b1;
  logic [31:0] PC_IF;
  logic [31:0] inst_IF;

  always #5 clk = ~clk;

  vscale_fetch_stage #(.START_PC(START), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .PC_PIF          (PC_PIF),
    .redirect        (redirect),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid_IF   (inst_valid_IF),
    .dx_ready        (dx_ready),
    .PC_IF           (PC_IF),
    .inst_IF         (inst_IF)
  );

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  flight_t     inflight[$];
  logic [31:0] buf_pc[$];
  mreq_t       mem_q[$];
  bit          m_run;
  logic [31:0] m_next_pc;
  logic [31:0] m_last_pc;
  int          last_due;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  bit k_dx_ready = 1'b1;
  bit k_rand_ready = 1'b0;
  bit k_rand_dx = 1'b0;
  int lat_min = 1;
  int lat_max = 1;

  logic        e_req;
  logic        e_valid;
  logic        e_pop;
  logic [31:0] e_pc;
  logic [31:0] e_inst;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive inputs and compare DUT outputs against the model for the current cycle.
  task automatic pre(bit redir = 1'b0, logic [31:0] tgt = 32'h0);
    int occ;
    redirect = redir;
    PC_PIF = tgt;
    imem_req_ready = k_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    dx_ready = k_rand_dx ? 1'($urandom_range(0, 1)) : k_dx_ready;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = mem_word(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = 32'hDEAD_BEEF;
    end
    #3;
    e_valid = (buf_pc.size() != 0) && !redirect;
    e_pop = e_valid && dx_ready;
    occ = inflight.size() + buf_pc.size() - (e_pop ? 1 : 0);
    e_req = m_run && !redirect && (occ < 2);
    e_pc = (buf_pc.size() != 0) ? buf_pc[0] : m_last_pc;
    e_inst = (buf_pc.size() != 0) ? mem_word(buf_pc[0]) : NOP;
    check("req_valid", 32'(imem_req_valid), 32'(e_req));
    check("imem_addr", imem_addr, m_next_pc);
    check("inst_valid", 32'(inst_valid_IF), 32'(e_valid));
    check("pc_if", PC_IF, e_pc);
    check("inst_if", inst_IF, e_inst);
  endtask

  // Advance model and memory across the rising edge.
  task automatic advance();
    flight_t f;
    mreq_t   m;
    bit      acc;
    @(posedge clk);
    acc = e_req && imem_req_ready;
    if (redirect) begin
      buf_pc.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      if (imem_resp_valid) f = inflight.pop_front();
      m_next_pc = PC_PIF;
    end else begin
      if (e_pop) m_last_pc = buf_pc.pop_front();
      if (imem_resp_valid) begin
        f = inflight.pop_front();
        if (!f.stale) begin
          check("fifo_no_overflow", 32'(buf_pc.size() < 2), 32'd1);
          buf_pc.push_back(f.pc);
        end
      end
    end
    if (imem_resp_valid) m = mem_q.pop_front();
    if (acc) begin
      m.addr = m_next_pc;
      m.due = cyc + $urandom_range(lat_min, lat_max);
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      mem_q.push_back(m);
      f.pc = m_next_pc;
      f.stale = 1'b0;
      inflight.push_back(f);
      m_next_pc = m_next_pc + 32'd4;
    end
    m_run = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic step(bit redir = 1'b0, logic [31:0] tgt = 32'h0);
    pre(redir, tgt);
    advance();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_addr", imem_addr, START);
    check("rst_inst_valid", 32'(inst_valid_IF), 32'd0);
    check("rst_pc_if", PC_IF, START - 32'd4);
    check("rst_inst_if", inst_IF, NOP);
    inflight.delete();
    buf_pc.delete();
    mem_q.delete();
    m_run = 1'b0;
    m_next_pc = START;
    m_last_pc = START - 32'd4;
    last_due = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    bit          found;
    bit          seen_fc;
    logic [31:0] tgt;

    #2;
    do_reset();

    // Startup: BOOT cycle, then back-to-back fetch from 0x200.
    pre(); check("boot_no_req", 32'(imem_req_valid), 32'd0); advance();
    pre(); check("first_req", 32'(imem_req_valid), 32'd1); check("first_addr", imem_addr, 32'h200); advance();
    pre(); check("second_addr", imem_addr, 32'h204); check("third_cycle_idle", 32'(inst_valid_IF), 32'd0); advance();
    pre(); check("fourth_valid", 32'(inst_valid_IF), 32'd1); check("fourth_pc", PC_IF, 32'h200); advance();
    pre(); check("fifth_pc", PC_IF, 32'h204); check("fifth_valid", 32'(inst_valid_IF), 32'd1); advance();
    repeat (10) step();

    // DX stall for 5 cycles.
    k_dx_ready = 1'b0;
    repeat (4) step();
    pre(); check("stall_no_req", 32'(imem_req_valid), 32'd0); check("stall_valid", 32'(inst_valid_IF), 32'd1); advance();
    k_dx_ready = 1'b1;
    repeat (10) step();

    // Redirect with two requests in flight (3-cycle memory).
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inflight.size() == 2 && buf_pc.size() == 0) found = 1'b1;
      else step();
    end
    check("two_in_flight_reached", 32'(found), 32'd1);
    step(1'b1, 32'h1000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      pre();
      if (imem_req_valid) begin check("redir_first_addr", imem_addr, 32'h1000); found = 1'b1; end
      advance();
    end
    check("redir_req_seen", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      pre();
      if (inst_valid_IF) begin check("redir_first_pc", PC_IF, 32'h1000); found = 1'b1; end
      advance();
    end
    check("redir_inst_seen", 32'(found), 32'd1);

    // Redirect coinciding with a response and dx_ready (1-cycle memory).
    lat_min = 1;
    lat_max = 1;
    repeat (6) step();
    pre(1'b1, 32'h3000);
    check("redir_resp_valid_low", 32'(inst_valid_IF), 32'd0);
    check("redir_resp_no_req", 32'(imem_req_valid), 32'd0);
    advance();
    pre(); check("redir_t1_addr", imem_addr, 32'h3000); check("redir_t1_req", 32'(imem_req_valid), 32'd1); advance();
    step();
    pre(); check("redir_t3_valid", 32'(inst_valid_IF), 32'd1); check("redir_t3_pc", PC_IF, 32'h3000); advance();

    // Random ready, latency, DX backpressure and occasional redirects.
    k_rand_ready = 1'b1;
    k_rand_dx = 1'b1;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 49) == 0, tgt);
    end

    // Address wrap at the top of memory.
    k_rand_ready = 1'b0;
    k_rand_dx = 1'b0;
    lat_min = 1;
    lat_max = 1;
    step(1'b1, 32'hFFFF_FFF8);
    found = 1'b0;
    seen_fc = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      pre();
      if (imem_req_valid) begin
        if (seen_fc) begin check("wrap_addr", imem_addr, 32'h0); found = 1'b1; end
        else if (imem_addr == 32'hFFFF_FFFC) seen_fc = 1'b1;
      end
      advance();
    end
    check("wrap_seen", 32'(found), 32'd1);
    repeat (8) step();

    // Asynchronous reset mid-stream, then restart.
    lat_min = 2;
    lat_max = 3;
    repeat (5) step();
    #2;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (25) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
